// File: rtl/add_serial_sched_if.sv
// ---------------------------------------------------------------------------
// add_serial_sched_if
// Bundles every signal of add_serial_sched except clk and rst: the requester
// side (req, a_in, b_in, gnt, rsp_valid, rsp_ready, rsp_data, busy) and the
// side that drives the shared bit-serial adder (add_a, add_b, add_en, add_out).
//   slave  : the scheduler's view (add_serial_sched uses this one)
//   master : everything outside the scheduler (requesters and the adder)
// ---------------------------------------------------------------------------
interface add_serial_sched_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_in;
    logic [N_REQ*W-1:0] b_in;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [N_REQ-1:0]   rsp_ready;
    logic [W-1:0]       rsp_data;
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic               add_en;
    logic [W-1:0]       add_out;
    logic               busy;

    modport slave (
        input  req, a_in, b_in, rsp_ready, add_out,
        output gnt, rsp_valid, rsp_data, add_a, add_b, add_en, busy
    );

    modport master (
        output req, a_in, b_in, rsp_ready, add_out,
        input  gnt, rsp_valid, rsp_data, add_a, add_b, add_en, busy
    );
endinterface

// File: rtl/add_serial_sched.sv
// ---------------------------------------------------------------------------
// add_serial_sched
// Shares one external bit-serial adder between N_REQ requesters. A winner is
// picked in IDLE, its operands are held on add_a/add_b for the whole
// transaction, the adder is started with add_en, its result is captured
// ADD_LAT cycles later and handed back to the winner with a valid/ready
// handshake; a final add_en pulse returns the adder to its idle state.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous, active-high reset (shared with the adder)
//   bus   : add_serial_sched_if.slave
//           req/a_in/b_in       requester level requests and packed operands
//           gnt                 one-hot pulse when the winner is accepted
//           rsp_valid/rsp_ready one-hot result handshake, rsp_data result
//           add_a/add_b/add_en  adder operands and start/release strobe
//           add_out             adder result
//           busy                high whenever the FSM is not in IDLE
//
// Build option
//   ADD_SCHED_RR_EN : defined   -> round-robin arbitration (pointer register)
//                     undefined -> fixed priority, lowest index wins
//
// State table
//   S_IDLE    | wait for any req; latch winner and its operands
//   S_LAUNCH  | gnt pulse, add_en pulse, load wait counter
//   S_WAIT    | ADD_LAT cycles while the adder runs
//   S_CAPTURE | register add_out into rsp_data
//   S_RESP    | rsp_valid to winner until its rsp_ready
//   S_RELEASE | add_en pulse returns the adder to idle
// ---------------------------------------------------------------------------
module add_serial_sched #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int ADD_LAT = 10
) (
    input  logic              clk,
    input  logic              rst,
    add_serial_sched_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_RESP,
        S_RELEASE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [W-1:0]       r_rsp_data;
    logic [W-1:0]       r_add_a;
    logic [W-1:0]       r_add_b;
    logic               r_add_en;

    logic               w_win_valid;
    logic [IDX_W-1:0]   w_win_idx;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [N_REQ-1:0]   w_rsp_valid_nxt;
    logic               w_add_en_nxt;

`ifdef ADD_SCHED_RR_EN
    logic [IDX_W-1:0]   r_rr_ptr;

    // Search starts one past the last winner and wraps.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_win_valid && bus.req[(int'(r_rr_ptr) + k) % N_REQ]) begin
                w_win_valid = 1'b1;
                w_win_idx   = IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= IDX_W'(N_REQ - 1);
        end else if (r_state == S_IDLE && w_win_valid) begin
            r_rr_ptr <= w_win_idx;
        end
    end
`else
    // Descending scan so the lowest requesting index is the last to write.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                w_win_valid = 1'b1;
                w_win_idx   = IDX_W'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the next value of every registered FSM output, so that
    // gnt/rsp_valid/add_en come straight from flops in the state they belong to.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_add_en_nxt    = 1'b0;

        case (r_state)
            S_IDLE:    if (w_win_valid) w_state_nxt = S_LAUNCH;
            S_LAUNCH:  w_state_nxt = S_WAIT;
            S_WAIT:    if (r_cnt == '0) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP:    if (bus.rsp_ready[r_win]) w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        // LAUNCH is only reachable from IDLE, so the fresh winner is used here.
        if (w_state_nxt == S_LAUNCH) begin
            w_gnt_nxt[w_win_idx] = 1'b1;
        end
        if (w_state_nxt == S_RESP) begin
            w_rsp_valid_nxt[r_win] = 1'b1;
        end
        w_add_en_nxt = (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_RELEASE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_en    <= 1'b0;
        end else begin
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_add_en    <= w_add_en_nxt;

            // Operands are latched only on acceptance and then held until the
            // next acceptance, so requester-side changes never reach the adder.
            if (r_state == S_IDLE && w_win_valid) begin
                r_win   <= w_win_idx;
                r_add_a <= bus.a_in[int'(w_win_idx) * W +: W];
                r_add_b <= bus.b_in[int'(w_win_idx) * W +: W];
            end

            if (r_state == S_LAUNCH) begin
                r_cnt <= CNT_W'(ADD_LAT - 1);
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // The adder itself is W bits wide, so any carry-out is already gone.
            if (r_state == S_CAPTURE) begin
                r_rsp_data <= bus.add_out;
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_en    = r_add_en;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
